// File: rtl/mem_image_loader_pkg.sv
// Shared types for the memory image loader.
// Holds the loader FSM state encoding, the load command codes, and a helper
// that maps an accepted command onto the first load phase it runs.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_PIX = 2'd1,
    LOAD_WEI = 2'd2,
    FINISH   = 2'd3
  } state_e;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PIX  = 2'b01;
  localparam logic [1:0] CMD_WEI  = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  // Pixels always go first when a command asks for them (01 and 11).
  function automatic state_e firstLoadState(input logic [1:0] cmd);
    return (cmd == CMD_PIX || cmd == CMD_BOTH) ? LOAD_PIX : LOAD_WEI;
  endfunction

endpackage

// File: rtl/mem_image_loader_if.sv
// Bundle of the loader's command, stream and memory-write signals.
//   master : the loader's view (takes command/stream, drives memory writes)
//   slave  : the environment's view (host front end plus memorywork)
// Signals:
//   start, cmd           command strobe and load selection
//   in_data, in_valid    incoming stream word and its valid
//   in_ready             loader accepts the stream word this cycle
//   data, address        write data/address towards memorywork
//   we_p, we_w           pixel / weight write strobes
//   re_RAM               memorywork read enable (low while loading)
//   GO, busy, cmd_err    start pulse, load in progress, sticky command error
interface mem_image_loader_if #(
  parameter int SIZE_1 = 8,
  parameter int ADDR_W = 13
);
  logic              start;
  logic [1:0]        cmd;
  logic [SIZE_1-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE_1-1:0] data;
  logic [ADDR_W-1:0] address;
  logic              we_p;
  logic              we_w;
  logic              re_RAM;
  logic              GO;
  logic              busy;
  logic              cmd_err;

  modport master (
    input  start, cmd, in_data, in_valid,
    output in_ready, data, address, we_p, we_w, re_RAM, GO, busy, cmd_err
  );

  modport slave (
    output start, cmd, in_data, in_valid,
    input  in_ready, data, address, we_p, we_w, re_RAM, GO, busy, cmd_err
  );
endinterface

// File: rtl/mem_image_loader_addr_counter.sv
// Write-address counter shared by the pixel and weight load phases.
// Ports:
//   clk, srstb  clock and asynchronous active-low reset
//   clear       restart the count at zero (wins over inc)
//   inc         advance by one accepted beat
//   limit       index of the final word of the current phase
//   count       address of the next word to be written
//   last        the next beat is the final one of the phase
module load_addr_counter #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              srstb,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // The owner clears the counter on the terminal beat, so it never needs to
  // run past limit and never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == limit);

endmodule

// File: rtl/mem_image_loader.sv
// Initiator side of the neuroset memory-load port. Takes a byte stream and
// writes it into memorywork as pixels and/or weights at incrementing
// addresses, then pulses GO once the commanded load has completed.
// Ports:
//   clk, srstb  clock and asynchronous active-low reset
//   bus         mem_image_loader_if master modport (command, stream, writes)
module mem_image_loader
  import loader_pkg::*;
#(
  parameter int SIZE_1    = 8,
  parameter int PIX_COUNT = 784,
  parameter int WEI_COUNT = 4000,
  parameter int ADDR_W    = 13
) (
  input  logic                clk,
  input  logic                srstb,
  mem_image_loader_if.master  bus
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_COUNT - 1);
  localparam logic [ADDR_W-1:0] WEI_LAST = ADDR_W'(WEI_COUNT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              cmdErr_q, cmdErr_d;
  logic [SIZE_1-1:0] data_q, data_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              weP_q, weP_d;
  logic              weW_q, weW_d;

  logic              inReady;
  logic              beat;
  logic              acceptStart;
  logic              cntClear;
  logic [ADDR_W-1:0] cntLimit;
  logic [ADDR_W-1:0] count;
  logic              last;

  assign beat        = bus.in_valid & inReady;
  assign acceptStart = (state_q == IDLE) && bus.start && (bus.cmd != CMD_NOP);

  load_addr_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clk   (clk),
    .srstb (srstb),
    .clear (cntClear),
    .inc   (beat),
    .limit (cntLimit),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A combined command hops straight from the last pixel beat into the
  // weight phase so the stream never sees a dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (acceptStart) state_d = firstLoadState(bus.cmd);
      LOAD_PIX: if (beat && last) state_d = (cmd_q == CMD_BOTH) ? LOAD_WEI : FINISH;
      LOAD_WEI: if (beat && last) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counter restarts on every phase entry: either a fresh command or the
  // terminal beat of a phase.
  always_comb begin
    inReady  = (state_q == LOAD_PIX) || (state_q == LOAD_WEI);
    cntLimit = (state_q == LOAD_PIX) ? PIX_LAST : WEI_LAST;
    cntClear = acceptStart || (beat && last);
  end

  // Each beat becomes a one-cycle write in the following cycle; data and
  // address are held between writes.
  always_comb begin
    data_d    = data_q;
    address_d = address_q;
    weP_d     = 1'b0;
    weW_d     = 1'b0;
    cmd_d     = cmd_q;
    cmdErr_d  = cmdErr_q;
    if (beat) begin
      data_d    = bus.in_data;
      address_d = count;
      weP_d     = (state_q == LOAD_PIX);
      weW_d     = (state_q == LOAD_WEI);
    end
    if (acceptStart) begin
      cmd_d    = bus.cmd;
      cmdErr_d = 1'b0;
    end else if (bus.start) begin
      cmdErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      data_q    <= '0;
      address_q <= '0;
      weP_q     <= 1'b0;
      weW_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
      cmdErr_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      address_q <= address_d;
      weP_q     <= weP_d;
      weW_q     <= weW_d;
      cmd_q     <= cmd_d;
      cmdErr_q  <= cmdErr_d;
    end
  end

  assign bus.in_ready = inReady;
  assign bus.data     = data_q;
  assign bus.address  = address_q;
  assign bus.we_p     = weP_q;
  assign bus.we_w     = weW_q;
  assign bus.re_RAM   = (state_q == IDLE);
  assign bus.GO       = (state_q == FINISH);
  assign bus.busy     = (state_q != IDLE);
  assign bus.cmd_err  = cmdErr_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed self-checking bench for mem_image_loader with small image sizes
// (4 pixels, 3 weights). A monitor logs every memory write and GO pulse;
// the main sequence compares those logs and sampled outputs against
// hand-computed values.
module tb_mem_image_loader;

  localparam int SIZE_1    = 8;
  localparam int PIX_COUNT = 4;
  localparam int WEI_COUNT = 3;
  localparam int ADDR_W    = 13;

  logic clk;
  logic srstb;

  mem_image_loader_if #(.SIZE_1(SIZE_1), .ADDR_W(ADDR_W)) bus ();

  mem_image_loader #(
    .SIZE_1    (SIZE_1),
    .PIX_COUNT (PIX_COUNT),
    .WEI_COUNT (WEI_COUNT),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk   (clk),
    .srstb (srstb),
    .bus   (bus)
  );

  int passCount  = 0;
  int checkCount = 0;
  int goCount    = 0;
  logic prevBeat;
  logic [ADDR_W-1:0] pixAddr[$];
  logic [SIZE_1-1:0] pixData[$];
  logic [ADDR_W-1:0] weiAddr[$];
  logic [SIZE_1-1:0] weiData[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Remember whether a beat was accepted on each edge so every strobe can be
  // traced back to one.
  always @(posedge clk or negedge srstb) begin
    if (!srstb) prevBeat <= 1'b0;
    else        prevBeat <= bus.in_valid & bus.in_ready;
  end

  always @(negedge clk) begin
    if (bus.we_p) begin
      pixAddr.push_back(bus.address);
      pixData.push_back(bus.data);
    end
    if (bus.we_w) begin
      weiAddr.push_back(bus.address);
      weiData.push_back(bus.data);
    end
    if (bus.GO) goCount++;
    if (bus.we_p || bus.we_w) checkOutput("strobeFollowsBeat", 32'(prevBeat), 32'd1);
  end

  task automatic clearLogs();
    pixAddr.delete(); pixData.delete();
    weiAddr.delete(); weiData.delete();
    goCount = 0;
  endtask

  task automatic sendStart(input logic [1:0] c);
    bus.start = 1'b1;
    bus.cmd   = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cmd   = 2'b00;
  endtask

  // Present one word, wait (bounded) for it to be taken, then idle for gap cycles.
  task automatic applyStimulus(input logic [SIZE_1-1:0] word, input int gap);
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    while (bus.in_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) checkOutput("beatTimeout", 32'(tries), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkPix(input int idx, input logic [SIZE_1-1:0] expData);
    checkOutput($sformatf("pixAddr%0d", idx), 32'(pixAddr[idx]), 32'(idx));
    checkOutput($sformatf("pixData%0d", idx), 32'(pixData[idx]), 32'(expData));
  endtask

  task automatic checkWei(input int idx, input logic [SIZE_1-1:0] expData);
    checkOutput($sformatf("weiAddr%0d", idx), 32'(weiAddr[idx]), 32'(idx));
    checkOutput($sformatf("weiData%0d", idx), 32'(weiData[idx]), 32'(expData));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    srstb        = 1'b0;
    bus.start    = 1'b0;
    bus.cmd      = 2'b00;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rstData",   32'(bus.data),     32'd0);
    checkOutput("rstAddr",   32'(bus.address),  32'd0);
    checkOutput("rstWeP",    32'(bus.we_p),     32'd0);
    checkOutput("rstWeW",    32'(bus.we_w),     32'd0);
    checkOutput("rstGo",     32'(bus.GO),       32'd0);
    checkOutput("rstBusy",   32'(bus.busy),     32'd0);
    checkOutput("rstReady",  32'(bus.in_ready), 32'd0);
    checkOutput("rstErr",    32'(bus.cmd_err),  32'd0);
    checkOutput("rstReRam",  32'(bus.re_RAM),   32'd1);
    srstb = 1'b1;
    @(negedge clk);

    // Pixels only, back-to-back stream
    clearLogs();
    sendStart(2'b01);
    checkOutput("t1Busy",  32'(bus.busy),     32'd1);
    checkOutput("t1ReRam", 32'(bus.re_RAM),   32'd0);
    checkOutput("t1Ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    checkOutput("t1Go",      32'(bus.GO),       32'd1);
    checkOutput("t1LastWe",  32'(bus.we_p),     32'd1);
    checkOutput("t1LastAdr", 32'(bus.address),  32'd3);
    checkOutput("t1FinBusy", 32'(bus.busy),     32'd1);
    checkOutput("t1FinRdy",  32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("t1BusyFall", 32'(bus.busy),   32'd0);
    checkOutput("t1GoFall",   32'(bus.GO),     32'd0);
    checkOutput("t1ReRamUp",  32'(bus.re_RAM), 32'd1);
    checkOutput("t1PixCnt",   32'(pixAddr.size()), 32'd4);
    checkOutput("t1WeiCnt",   32'(weiAddr.size()), 32'd0);
    checkOutput("t1GoCnt",    32'(goCount), 32'd1);
    checkPix(0, 8'h11); checkPix(1, 8'h22); checkPix(2, 8'h33); checkPix(3, 8'h44);

    // Pixels then weights with two-cycle gaps
    clearLogs();
    sendStart(2'b11);
    applyStimulus(8'hA0, 2);
    applyStimulus(8'hA1, 2);
    applyStimulus(8'hA2, 2);
    applyStimulus(8'hA3, 2);
    checkOutput("t2MidReady", 32'(bus.in_ready), 32'd1);
    checkOutput("t2MidBusy",  32'(bus.busy),     32'd1);
    applyStimulus(8'hA4, 2);
    applyStimulus(8'hA5, 2);
    applyStimulus(8'hA6, 2);
    checkOutput("t2PixCnt", 32'(pixAddr.size()), 32'd4);
    checkOutput("t2WeiCnt", 32'(weiAddr.size()), 32'd3);
    checkOutput("t2GoCnt",  32'(goCount), 32'd1);
    checkOutput("t2Idle",   32'(bus.busy), 32'd0);
    checkPix(0, 8'hA0); checkPix(3, 8'hA3);
    checkWei(0, 8'hA4); checkWei(1, 8'hA5); checkWei(2, 8'hA6);

    // Start while busy: flagged, load unaffected
    clearLogs();
    sendStart(2'b01);
    applyStimulus(8'h61, 0);
    applyStimulus(8'h62, 0);
    bus.start    = 1'b1;
    bus.cmd      = 2'b01;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h63;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.cmd      = 2'b00;
    bus.in_valid = 1'b0;
    checkOutput("t4ErrSet", 32'(bus.cmd_err), 32'd1);
    checkOutput("t4Busy",   32'(bus.busy),    32'd1);
    applyStimulus(8'h64, 0);
    checkOutput("t4Go", 32'(bus.GO), 32'd1);
    @(negedge clk);
    checkOutput("t4PixCnt", 32'(pixAddr.size()), 32'd4);
    checkOutput("t4ErrHeld", 32'(bus.cmd_err), 32'd1);
    checkPix(2, 8'h63); checkPix(3, 8'h64);

    // Weights only; this valid start also clears the error
    clearLogs();
    sendStart(2'b10);
    checkOutput("t3ErrClr", 32'(bus.cmd_err),  32'd0);
    checkOutput("t3ReRam",  32'(bus.re_RAM),   32'd0);
    checkOutput("t3Ready",  32'(bus.in_ready), 32'd1);
    applyStimulus(8'h51, 0);
    applyStimulus(8'h52, 0);
    applyStimulus(8'h53, 0);
    checkOutput("t3Go",      32'(bus.GO),     32'd1);
    checkOutput("t3GoReRam", 32'(bus.re_RAM), 32'd0);
    checkOutput("t3LastWeW", 32'(bus.we_w),   32'd1);
    @(negedge clk);
    checkOutput("t3ReRamUp", 32'(bus.re_RAM), 32'd1);
    checkOutput("t3PixCnt", 32'(pixAddr.size()), 32'd0);
    checkOutput("t3WeiCnt", 32'(weiAddr.size()), 32'd3);
    checkWei(0, 8'h51); checkWei(1, 8'h52); checkWei(2, 8'h53);

    // Reset in the middle of a pixel load
    clearLogs();
    sendStart(2'b01);
    applyStimulus(8'h71, 0);
    applyStimulus(8'h72, 0);
    srstb = 1'b0;
    #1;
    checkOutput("t5Data",  32'(bus.data),     32'd0);
    checkOutput("t5Addr",  32'(bus.address),  32'd0);
    checkOutput("t5WeP",   32'(bus.we_p),     32'd0);
    checkOutput("t5Busy",  32'(bus.busy),     32'd0);
    checkOutput("t5Ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t5Go",    32'(bus.GO),       32'd0);
    checkOutput("t5ReRam", 32'(bus.re_RAM),   32'd1);
    repeat (2) @(negedge clk);
    srstb = 1'b1;
    @(negedge clk);
    checkOutput("t5NoGo", 32'(goCount), 32'd0);
    clearLogs();
    sendStart(2'b01);
    applyStimulus(8'h81, 0);
    applyStimulus(8'h82, 0);
    applyStimulus(8'h83, 0);
    applyStimulus(8'h84, 0);
    @(negedge clk);
    checkOutput("t5PixCnt", 32'(pixAddr.size()), 32'd4);
    checkOutput("t5GoCnt",  32'(goCount), 32'd1);
    checkPix(0, 8'h81); checkPix(3, 8'h84);

    // No-op command: stays idle and refuses the stream
    clearLogs();
    sendStart(2'b00);
    checkOutput("t6Err",   32'(bus.cmd_err),  32'd1);
    checkOutput("t6Busy",  32'(bus.busy),     32'd0);
    checkOutput("t6Ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6Refuse%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6NoWrites", 32'(pixAddr.size() + weiAddr.size()), 32'd0);
    checkOutput("t6AddrHeld", 32'(bus.address), 32'd3);
    checkOutput("t6DataHeld", 32'(bus.data),    32'h84);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
